// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
//   8N1 UART transmitter fed by a small byte FIFO. Software queues bytes
//   through i_TX_DV/i_TX_Byte; the FSM drains the FIFO one frame at a time,
//   using the bit-period divisor latched at the start of each frame.
//
// Ports
//   i_Clock       system clock
//   i_Reset_n     asynchronous active-low reset
//   CLKS_PER_BIT  clocks per serial bit (values 0 and 1 behave as 2)
//   i_TX_DV       write strobe, enqueues i_TX_Byte when o_TX_Ready is high
//   i_TX_Byte     byte to enqueue
//   o_TX_Ready    FIFO not full (registered)
//   o_TX_Overrun  one-cycle pulse after a write was dropped on a full FIFO
//   o_FIFO_Count  bytes waiting in the FIFO, excluding the byte in flight
//   o_TX_Serial   serial line, idle high
//   o_TX_Active   high from start bit through stop bit
//   o_TX_Done     one-cycle pulse after each stop bit
//
// state   | meaning
// IDLE    | line high, pop next byte and latch divisor when FIFO non-empty
// START   | start bit (low) for D clocks
// DATA    | 8 data bits LSB first, D clocks each
// STOP    | stop bit (high) for D clocks
// CLEANUP | single cycle, o_TX_Done asserted

module uart_tx_buffered #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset_n,
  input  logic [15:0]                   CLKS_PER_BIT,
  input  logic                          i_TX_DV,
  input  logic [7:0]                    i_TX_Byte,
  output logic                          o_TX_Ready,
  output logic                          o_TX_Overrun,
  output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count,
  output logic                          o_TX_Serial,
  output logic                          o_TX_Active,
  output logic                          o_TX_Done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ready_q, overrun_q;

  state_t        state_q;
  logic [7:0]    shift_q;
  logic [15:0]   div_q, clk_cnt_q;
  logic [2:0]    bit_idx_q;
  logic          serial_q, active_q, done_q;

  logic          push, pop, bit_end;
  logic [15:0]   div_eff;

  // Ready is registered, so a write that meets a full FIFO is dropped even
  // if the FSM pops on the very same edge.
  assign push    = i_TX_DV & ready_q;
  assign pop     = (state_q == IDLE) && (count_q != '0);
  assign div_eff = (CLKS_PER_BIT < 16'd2) ? 16'd2 : CLKS_PER_BIT;
  assign bit_end = (clk_cnt_q == div_q - 16'd1);

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge i_Clock) begin
    if (push) mem_q[wr_ptr_q] <= i_TX_Byte;
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ready_q   <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q   <= count_d;
      ready_q   <= (count_d != FULL_CNT);
      overrun_q <= i_TX_DV & ~ready_q;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      div_q     <= 16'd2;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          serial_q <= 1'b1;
          active_q <= 1'b0;
          done_q   <= 1'b0;
          if (pop) begin
            shift_q   <= mem_q[rd_ptr_q];
            div_q     <= div_eff;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            serial_q  <= 1'b0;
            active_q  <= 1'b1;
            state_q   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            serial_q  <= shift_q[0];
            state_q   <= DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              serial_q <= 1'b1;
              state_q  <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              serial_q  <= shift_q[bit_idx_q + 3'd1];
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            active_q  <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= CLEANUP;
          end else begin
            clk_cnt_q <= clk_cnt_q + 16'd1;
          end
        end
        CLEANUP: begin
          serial_q <= 1'b1;
          done_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_TX_Ready   = ready_q;
  assign o_TX_Overrun = overrun_q;
  assign o_FIFO_Count = count_q;
  assign o_TX_Serial  = serial_q;
  assign o_TX_Active  = active_q;
  assign o_TX_Done    = done_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
module tb_uart_tx_buffered;

  localparam int LOGN = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] cpb = 16'd4;
  logic        dv = 1'b0;
  logic [7:0]  tx_byte = 8'h00;
  logic        ready, overrun, serial, active, done;
  logic [2:0]  fcount;

  uart_tx_buffered #(.FIFO_DEPTH(4)) dut (
    .i_Clock      (clk),
    .i_Reset_n    (rst_n),
    .CLKS_PER_BIT (cpb),
    .i_TX_DV      (dv),
    .i_TX_Byte    (tx_byte),
    .o_TX_Ready   (ready),
    .o_TX_Overrun (overrun),
    .o_FIFO_Count (fcount),
    .o_TX_Serial  (serial),
    .o_TX_Active  (active),
    .o_TX_Done    (done)
  );

  always #5 clk = ~clk;

  // cycle log: sample index n is taken 1 time unit after the n-th rising edge
  int   cyc = 0;
  logic s_log [LOGN];
  logic a_log [LOGN];
  logic d_log [LOGN];
  logic r_log [LOGN];
  logic o_log [LOGN];
  logic [2:0] c_log [LOGN];

  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    s_log[cyc % LOGN] = serial;
    a_log[cyc % LOGN] = active;
    d_log[cyc % LOGN] = done;
    r_log[cyc % LOGN] = ready;
    o_log[cyc % LOGN] = overrun;
    c_log[cyc % LOGN] = fcount;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  // reference: list of back-to-back frames (byte, effective divisor)
  logic [7:0] fb [8];
  int         fd [8];
  int         nf;

  function automatic int eff(int d);
    return (d < 2) ? 2 : d;
  endfunction

  // expected {serial, active, done} at offset 'off' cycles from the first
  // start-bit cycle of frame 0; frames follow each other every 10*D+2 cycles
  function automatic logic [2:0] model(int off);
    int o;
    o = off;
    for (int j = 0; j < nf; j++) begin
      int L;
      L = 10 * fd[j];
      if (o < L) begin
        int   idx;
        logic s;
        idx = o / fd[j];
        if (idx == 0)      s = 1'b0;
        else if (idx == 9) s = 1'b1;
        else               s = fb[j][idx-1];
        return {s, 1'b1, 1'b0};
      end
      if (o == L)     return 3'b101;
      if (o == L + 1) return 3'b100;
      o -= L + 2;
    end
    return 3'b100;
  endfunction

  function automatic int frames_len();
    int t;
    t = 0;
    for (int j = 0; j < nf; j++) t += 10 * fd[j] + 2;
    return t;
  endfunction

  function automatic logic [2:0] obs(int c);
    return {s_log[c % LOGN], a_log[c % LOGN], d_log[c % LOGN]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_until(int t);
    int guard;
    guard = 0;
    while (cyc < t && guard < 5000) begin
      tick();
      guard++;
    end
  endtask

  task automatic do_write(logic [7:0] b);
    dv = 1'b1;
    tx_byte = b;
    tick();
    dv = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #3;
    checks++;
    if ({serial, ready, overrun, active, done, fcount} !== 8'b11000_000) begin
      errors++;
      $display("FAIL reset_vals got=%b exp=%b", {serial, ready, overrun, active, done, fcount}, 8'b11000_000);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if ({serial, ready, overrun, active, done, fcount} !== 8'b11000_000) begin
      errors++;
      $display("FAIL post_reset_idle got=%b exp=%b", {serial, ready, overrun, active, done, fcount}, 8'b11000_000);
    end
  endtask

  task automatic test_single();
    int st, n_act, done_at;
    cpb = 16'd4;
    nf = 1; fb[0] = 8'hA5; fd[0] = 4;
    do_write(8'hA5);
    st = cyc + 1;
    checks++;
    if (s_log[(st-1) % LOGN] !== 1'b1 || c_log[(st-1) % LOGN] !== 3'd1) begin
      errors++;
      $display("FAIL single_write_edge serial=%b count=%0d exp serial=1 count=1", s_log[(st-1) % LOGN], c_log[(st-1) % LOGN]);
    end
    wait_until(st + 45);
    n_act = 0; done_at = -1;
    for (int c = 0; c < 45; c++) begin
      checks++;
      if (obs(st + c) !== model(c)) begin
        errors++;
        $display("FAIL single_frame cyc=%0d got=%b exp=%b", c, obs(st + c), model(c));
      end
      if (a_log[(st + c) % LOGN] === 1'b1) n_act++;
      if (d_log[(st + c) % LOGN] === 1'b1 && done_at < 0) done_at = c + 1;
    end
    checks++;
    if (n_act !== 40 || done_at !== 41) begin
      errors++;
      $display("FAIL single_window active=%0d done_at=%0d exp 40 and 41", n_act, done_at);
    end
  endtask

  task automatic test_burst();
    int st, n, n_ovr;
    cpb = 16'd8;
    nf = 5;
    for (int j = 0; j < 5; j++) begin
      fb[j] = 8'(j + 1);
      fd[j] = 8;
    end
    do_write(8'h01);
    st = cyc + 1;
    for (int b = 2; b <= 5; b++) do_write(8'(b));
    checks++;
    if (ready !== 1'b0 || fcount !== 3'd4) begin
      errors++;
      $display("FAIL burst_full ready=%b count=%0d exp ready=0 count=4", ready, fcount);
    end
    do_write(8'h06);
    checks++;
    if (overrun !== 1'b1 || fcount !== 3'd4 || ready !== 1'b0) begin
      errors++;
      $display("FAIL burst_overrun ovr=%b count=%0d ready=%b exp 1 4 0", overrun, fcount, ready);
    end
    tick();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL burst_overrun_pulse ovr=%b exp 0", overrun);
    end
    n = frames_len() + 5;
    wait_until(st + n);
    n_ovr = 0;
    for (int c = 0; c < n; c++) begin
      checks++;
      if (obs(st + c) !== model(c)) begin
        errors++;
        $display("FAIL burst_frames cyc=%0d got=%b exp=%b", c, obs(st + c), model(c));
      end
      if (o_log[(st + c) % LOGN] === 1'b1) n_ovr++;
    end
    checks++;
    if (n_ovr !== 1) begin
      errors++;
      $display("FAIL burst_overrun_count got=%0d exp=1", n_ovr);
    end
    checks++;
    if (r_log[(st + 81) % LOGN] !== 1'b0 || c_log[(st + 81) % LOGN] !== 3'd4 ||
        r_log[(st + 82) % LOGN] !== 1'b1 || c_log[(st + 82) % LOGN] !== 3'd3) begin
      errors++;
      $display("FAIL burst_ready_rise before=%b/%0d after=%b/%0d exp 0/4 then 1/3",
               r_log[(st + 81) % LOGN], c_log[(st + 81) % LOGN], r_log[(st + 82) % LOGN], c_log[(st + 82) % LOGN]);
    end
  endtask

  task automatic test_div_change();
    int st, n;
    cpb = 16'd4;
    nf = 2; fb[0] = 8'h3C; fd[0] = 4; fb[1] = 8'hC3; fd[1] = 6;
    do_write(8'h3C);
    st = cyc + 1;
    do_write(8'hC3);
    wait_until(st + 17);
    cpb = 16'd6;
    n = frames_len() + 4;
    wait_until(st + n);
    for (int c = 0; c < n; c++) begin
      checks++;
      if (obs(st + c) !== model(c)) begin
        errors++;
        $display("FAIL div_change cyc=%0d got=%b exp=%b", c, obs(st + c), model(c));
      end
    end
  endtask

  task automatic test_degenerate();
    int st, n_act;
    cpb = 16'd0;
    nf = 1; fb[0] = 8'hFF; fd[0] = eff(0);
    do_write(8'hFF);
    st = cyc + 1;
    wait_until(st + 25);
    n_act = 0;
    for (int c = 0; c < 25; c++) begin
      checks++;
      if (obs(st + c) !== model(c)) begin
        errors++;
        $display("FAIL degenerate cyc=%0d got=%b exp=%b", c, obs(st + c), model(c));
      end
      if (a_log[(st + c) % LOGN] === 1'b1) n_act++;
    end
    checks++;
    if (n_act !== 20) begin
      errors++;
      $display("FAIL degenerate_active got=%0d exp=20", n_act);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      int d, st, n;
      d = $urandom_range(0, 6);
      cpb = 16'(d);
      nf = 3;
      for (int j = 0; j < 3; j++) begin
        fb[j] = 8'($urandom_range(0, 255));
        fd[j] = eff(d);
      end
      do_write(fb[0]);
      st = cyc + 1;
      do_write(fb[1]);
      do_write(fb[2]);
      n = frames_len() + 3;
      wait_until(st + n);
      for (int c = 0; c < n; c++) begin
        checks++;
        if (obs(st + c) !== model(c)) begin
          errors++;
          $display("FAIL random it=%0d d=%0d cyc=%0d got=%b exp=%b", it, d, c, obs(st + c), model(c));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int st, rs, n;
    logic [7:0] b;
    cpb = 16'd4;
    do_write(8'h55);
    st = cyc + 1;
    do_write(8'hAA);
    wait_until(st + 17);
    rs = cyc;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({serial, ready, overrun, active, done, fcount} !== 8'b11000_000) begin
      errors++;
      $display("FAIL reset_mid_now got=%b exp=%b", {serial, ready, overrun, active, done, fcount}, 8'b11000_000);
    end
    tick();
    tick();
    rst_n = 1'b1;
    wait_until(rs + 60);
    for (int c = rs + 1; c <= rs + 60; c++) begin
      checks++;
      if (obs(c) !== 3'b100) begin
        errors++;
        $display("FAIL reset_mid_quiet cyc=%0d got=%b exp=100", c - rs, obs(c));
      end
    end
    b = 8'($urandom_range(0, 255));
    nf = 1; fb[0] = b; fd[0] = 4;
    do_write(b);
    st = cyc + 1;
    n = frames_len() + 2;
    wait_until(st + n);
    for (int c = 0; c < n; c++) begin
      checks++;
      if (obs(st + c) !== model(c)) begin
        errors++;
        $display("FAIL reset_recover cyc=%0d got=%b exp=%b", c, obs(st + c), model(c));
      end
    end
  endtask

  task automatic test_simul_push_pop();
    int st, n;
    cpb = 16'd3;
    nf = 4;
    for (int j = 0; j < 4; j++) begin
      fb[j] = 8'($urandom_range(0, 255));
      fd[j] = 3;
    end
    do_write(fb[0]);
    st = cyc + 1;
    do_write(fb[1]);
    do_write(fb[2]);
    wait_until(st + 31);
    checks++;
    if (fcount !== 3'd2) begin
      errors++;
      $display("FAIL simul_pre count=%0d exp=2", fcount);
    end
    dv = 1'b1;
    tx_byte = fb[3];
    tick();
    dv = 1'b0;
    checks++;
    if (fcount !== 3'd2 || overrun !== 1'b0 || serial !== 1'b0) begin
      errors++;
      $display("FAIL simul_edge count=%0d ovr=%b serial=%b exp 2 0 0", fcount, overrun, serial);
    end
    tick();
    checks++;
    if (overrun !== 1'b0 || fcount !== 3'd2) begin
      errors++;
      $display("FAIL simul_after ovr=%b count=%0d exp 0 2", overrun, fcount);
    end
    n = frames_len() + 3;
    wait_until(st + n);
    for (int c = 0; c < n; c++) begin
      checks++;
      if (obs(st + c) !== model(c)) begin
        errors++;
        $display("FAIL simul_frames cyc=%0d got=%b exp=%b", c, obs(st + c), model(c));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_div_change();
    test_degenerate();
    test_random();
    test_reset_mid();
    test_simul_push_pop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
